// File: rtl/trade_pkg.sv
// Shared message layout, field positions and action encodings for the
// trade decision stage.
package trade_pkg;

  localparam int MSG_W   = 178;
  localparam int PRICE_W = 64;

  localparam int TYPE_HI  = 177;
  localparam int TYPE_LO  = 176;
  localparam int STOCK_HI = 175;
  localparam int STOCK_LO = 144;
  localparam int PRICE_HI = 143;
  localparam int PRICE_LO = 80;
  localparam int QTY_HI   = 79;
  localparam int QTY_LO   = 72;

  localparam logic [1:0] ACT_BUY  = 2'b01;
  localparam logic [1:0] ACT_SELL = 2'b10;

  typedef struct packed {
    logic [TYPE_HI-TYPE_LO:0]   typ;
    logic [STOCK_HI-STOCK_LO:0] stock;
    logic [PRICE_HI-PRICE_LO:0] price;
    logic [QTY_HI-QTY_LO:0]     qty;
    logic [QTY_LO-1:0]          aux;
  } msg_t;

endpackage

// File: rtl/trade_decision.sv
// Compares message price against the running average and holds the resulting
// buy/sell trade in a single-entry valid/yumi output register.
module trade_decision
  import trade_pkg::*;
#(
  parameter int MSG_W   = trade_pkg::MSG_W,
  parameter int PRICE_W = trade_pkg::PRICE_W
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [MSG_W-1:0]   message_i,
  input  logic [PRICE_W-1:0] average_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [MSG_W-1:0]   trade_o
);

  msg_t msg;
  msg_t trade_q, trade_d;
  logic v_q, v_d;
  logic accept;

  assign msg     = msg_t'(message_i);
  assign ready_o = ~v_q;
  assign accept  = v_i & ~v_q;

  always_comb begin
    v_d     = v_q;
    trade_d = trade_q;
    if (v_q && yumi_i) v_d = 1'b0;
    // Zero price must be screened first: it would otherwise look like a buy.
    if (accept && (msg.price != '0)) begin
      if (msg.price < average_i) begin
        v_d       = 1'b1;
        trade_d   = msg;
        trade_d.typ = ACT_BUY;
      end else if (msg.price > average_i) begin
        v_d       = 1'b1;
        trade_d   = msg;
        trade_d.typ = ACT_SELL;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q     <= 1'b0;
      trade_q <= '0;
    end else begin
      v_q     <= v_d;
      trade_q <= trade_d;
    end
  end

  assign v_o     = v_q;
  assign trade_o = trade_q;

endmodule

// File: tb/tb_trade_decision.sv
// Scoreboard bench for trade_decision: expected trades are queued at send time
// and compared when the bench dequeues them with yumi_i.
module tb_trade_decision;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         v_i;
  logic         ready_o;
  logic [177:0] message_i;
  logic [63:0]  average_i;
  logic         v_o;
  logic         yumi_i;
  logic [177:0] trade_o;

  logic [177:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  trade_decision dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .message_i (message_i),
    .average_i (average_i),
    .v_o       (v_o),
    .yumi_i    (yumi_i),
    .trade_o   (trade_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [177:0] got, input logic [177:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [177:0] mk(input logic [1:0] typ, input logic [31:0] stock,
                                      input logic [63:0] price, input logic [7:0] qty,
                                      input logic [71:0] aux);
    return {typ, stock, price, qty, aux};
  endfunction

  function automatic logic [177:0] expect_of(input logic [177:0] m, input logic [63:0] avg,
                                             output bit trades);
    logic [63:0] p;
    p = m[143:80];
    trades = 1'b1;
    if (p == 64'd0 || p == avg) begin
      trades = 1'b0;
      return '0;
    end
    return (p < avg) ? {2'b01, m[175:0]} : {2'b10, m[175:0]};
  endfunction

  // One-cycle message pulse; assumes ready_o is high when called.
  task automatic send(input logic [177:0] m, input logic [63:0] avg);
    bit t;
    logic [177:0] e;
    @(posedge clk_i); #1;
    v_i = 1'b1; message_i = m; average_i = avg;
    e = expect_of(m, avg, t);
    if (t) exp_q.push_back(e);
    @(posedge clk_i); #1;
    v_i = 1'b0;
  endtask

  task automatic consume(input string tag);
    logic [177:0] e;
    int k;
    k = 0;
    @(negedge clk_i);
    while (!v_o && k < 8) begin @(negedge clk_i); k++; end
    chk({tag, "_vo"}, 178'(v_o), 178'(1));
    chk({tag, "_rdy"}, 178'(ready_o), 178'(0));
    if (exp_q.size() == 0) begin
      chk({tag, "_sbempty"}, 178'(1), 178'(0));
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_trade"}, trade_o, e);
    end
    @(posedge clk_i); #1; yumi_i = 1'b1;
    @(posedge clk_i); #1; yumi_i = 1'b0;
    @(negedge clk_i);
    chk({tag, "_deq_vo"}, 178'(v_o), 178'(0));
    chk({tag, "_deq_rdy"}, 178'(ready_o), 178'(1));
  endtask

  task automatic no_trade(input string tag);
    @(negedge clk_i);
    chk({tag, "_vo"}, 178'(v_o), 178'(0));
    chk({tag, "_rdy"}, 178'(ready_o), 178'(1));
    chk({tag, "_sb"}, 178'(exp_q.size()), 178'(0));
  endtask

  initial begin
    logic [177:0] ma, mb, ea;
    logic [63:0]  pr;
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; message_i = '0; average_i = '0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_vo", 178'(v_o), 178'(0));
    chk("rst_trade", trade_o, '0);
    chk("rst_rdy", 178'(ready_o), 178'(1));

    // Buy, with non-zero type bits to show they are overwritten
    send(mk(2'b11, 32'h2375_BAD8, 64'd12, 8'h50, 72'hAB_CDEF_0123_4567_89AB), 64'd10000);
    @(negedge clk_i);
    chk("buy_hold_vo", 178'(v_o), 178'(1));
    consume("buy");

    send(mk(2'b00, 32'h0000_1111, 64'd20000, 8'h07, 72'h1), 64'd10000);
    consume("sell");

    send(mk(2'b10, 32'hDEAD_BEEF, 64'd10000, 8'h01, 72'h2), 64'd10000);
    no_trade("equal");

    send(mk(2'b01, 32'hCAFE_0001, 64'd0, 8'h02, 72'h3), 64'd10000);
    no_trade("zero");

    // Unsigned compare: top-bit price must sell
    send(mk(2'b00, 32'h0BAD_F00D, 64'hFFFF_0000_0000_0000, 8'h09, 72'h4), 64'd10000);
    consume("bigsell");

    // yumi with nothing held is ignored
    @(posedge clk_i); #1 yumi_i = 1'b1;
    @(posedge clk_i); #1 yumi_i = 1'b0;
    no_trade("idle_yumi");

    // Backpressure: second message held on v_i while first trade waits
    ma = mk(2'b00, 32'h1234_5678, 64'd500, 8'h11, 72'h55);
    mb = mk(2'b00, 32'h8765_4321, 64'd15000, 8'h22, 72'h66);
    send(ma, 64'd10000);
    ea = exp_q[0];
    #1 v_i = 1'b1; message_i = mb; average_i = 64'd10000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("bp_vo", 178'(v_o), 178'(1));
      chk("bp_trade", trade_o, ea);
    end
    void'(exp_q.pop_front());
    @(posedge clk_i); #1 yumi_i = 1'b1;
    @(posedge clk_i); #1 yumi_i = 1'b0;
    @(negedge clk_i);
    chk("bp_deq_vo", 178'(v_o), 178'(0));
    chk("bp_deq_trade", trade_o, ea);
    exp_q.push_back({2'b10, mb[175:0]});
    @(posedge clk_i); #1 v_i = 1'b0;
    consume("bp_second");

    // Randomized prices around the average
    for (int i = 0; i < 12; i++) begin
      pr = 64'($urandom_range(0, 4)) * 64'd5000;
      send(mk(2'($urandom), $urandom, pr, 8'($urandom), {$urandom, $urandom, 8'($urandom)}), 64'd10000);
      if (exp_q.size() != 0) consume("rnd");
      else no_trade("rnd_none");
    end

    // Reset during hold, with a simultaneous would-be accept
    send(mk(2'b00, 32'h7777_0000, 64'd1, 8'h33, 72'h7), 64'd10000);
    @(negedge clk_i);
    chk("mid_pre_vo", 178'(v_o), 178'(1));
    @(posedge clk_i); #1;
    reset_i = 1'b1; yumi_i = 1'b1; v_i = 1'b1;
    message_i = mk(2'b00, 32'h1, 64'd2, 8'h1, 72'h1);
    @(posedge clk_i); #1;
    reset_i = 1'b0; yumi_i = 1'b0; v_i = 1'b0;
    exp_q.delete();
    chk("mid_rst_vo", 178'(v_o), 178'(0));
    chk("mid_rst_trade", trade_o, '0);
    chk("mid_rst_rdy", 178'(ready_o), 178'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1);
  end

endmodule

// File: doc/trade_decision.md
Name: trade_decision

Overview:
- Per-message trading decision stage downstream of the market-feed parser and moving-average unit.
- Accepts one 178-bit market message plus the current 64-bit average price.
- Compares the message price against the average and emits a buy or sell trade message.
- Holds the trade in a single-entry output register with a valid/yumi handshake toward the order-entry stage.

Parameters:
- MSG_W, 178, message and trade width.
- PRICE_W, 64, width of the price field and of average_i. Unsigned fixed-point, 2 implied decimals: 100.00 is encoded as 10000.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  synchronous active-high reset
- v_i  input  1  message_i/average_i valid
- ready_o  output  1  block can accept a message this cycle
- message_i  input  178  market message
- average_i  input  64  current average price, same fixed-point format as the price field
- v_o  output  1  trade_o holds a valid trade
- yumi_i  input  1  consumer takes trade_o this cycle; legal only while v_o=1
- trade_o  output  178  trade message

Behaviour:
- Interface: one clock clk_i; reset_i is synchronous and active-high.
- Message fields:
  - [177:176] type
  - [175:144] stock id
  - [143:80] price, 64-bit unsigned
  - [79:72] quantity
  - [71:0] auxiliary, passed through untouched
- Reset: v_o=0, trade_o=0, ready_o=1. Any held trade is discarded.
- ready_o = ~v_o. It is derived from the registered v_o and never depends combinationally on v_i or yumi_i.
- Accept occurs on a clock edge with v_i & ready_o. message_i and average_i are sampled on that same edge only.
- Decision on accept, using an unsigned compare:
  - price == 0: invalid message. It is consumed and dropped; v_o stays 0.
  - price < average_i: buy. trade_o <= {2'b01, message_i[175:0]}; v_o <= 1.
  - price > average_i: sell. trade_o <= {2'b10, message_i[175:0]}; v_o <= 1.
  - price == average_i: no trade. The message is dropped; v_o stays 0.
- Message type bits [177:176] never affect the decision; they are overwritten in trade_o.
- Latency: v_o rises on the edge that accepts the message, so trade_o is visible the following cycle.
- Output hold: trade_o and v_o remain stable while v_o=1 and yumi_i=0.
- Dequeue: yumi_i=1 with v_o=1 clears v_o on that edge. ready_o returns to 1 the next cycle; there is no same-cycle bypass.
- trade_o keeps its last value after dequeue.
- yumi_i while v_o=0 is ignored.
- v_i while ready_o=0 is ignored; the upstream stage must hold its data. Nothing is queued.
- reset_i has priority over every other input, including mid-hold and a simultaneous accept.
- No X propagation: with reset applied, all outputs are defined.

Decomposition:
- Package trade_pkg:
  - MSG_W and PRICE_W
  - field-position localparams TYPE_HI/LO, STOCK_HI/LO, PRICE_HI/LO, QTY_HI/LO
  - action encodings ACT_BUY=2'b01 and ACT_SELL=2'b10
  - a packed struct type msg_t for the message layout
- No sub-module: the comparator and output register stay in one module.

Test Plan:
- Reset: hold reset_i 2 cycles -> v_o=0, trade_o=0, ready_o=1.
- Buy: average_i=10000, price=12, stock=32'h2375_BAD8, qty=8'h50, v_i for 1 cycle -> next cycle v_o=1, trade_o[177:176]=01, trade_o[175:0]==message_i[175:0], ready_o=0. v_o held until yumi_i; after yumi_i, v_o=0 and ready_o=1.
- Sell and equal:
  - price=20000, average=10000 -> trade_o[177:176]=10, v_o=1.
  - price=10000, average=10000 -> v_o stays 0 and ready_o stays 1.
- Zero price: price=0, average=10000 -> message consumed, v_o stays 0.
- Backpressure: trade held, v_i held high with a second message, yumi_i=0 for 3 cycles -> trade_o unchanged and second message not taken. Assert yumi_i -> second message accepted the cycle after ready_o rises.
- Reset mid-hold: v_o=1, then reset_i=1 -> next cycle v_o=0 and trade_o=0.
